// File: rtl/nes_bus_pkg.sv
// Shared CPU/memory bus types for the NES core.
// Holds the sprite DMA state encoding and its default addresses.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  localparam int STALL_MIN = 513;
  localparam int STALL_MAX = 514;

endpackage

// File: rtl/oam_dma_arbiter.sv
// CPU / sprite-DMA bus arbiter.
// A write to the trigger register stalls the CPU and copies a page to OAM.
module oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter int              ADDR_W        = 16,
  parameter int              DATA_W        = 8,
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_wen,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_din,
  output logic              dma_busy
);

  dma_state_t r_state;
  logic       r_parity;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_data_q;
  logic       w_trig;

  assign w_trig   = cpu_wen && (cpu_addr == DMA_REG_ADDR);
  assign cpu_din  = mem_din;
  assign cpu_rdy  = (r_state == IDLE);
  assign dma_busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_data_q <= 8'h00;
    end else begin
      r_parity <= ~r_parity;
      unique case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_page  <= cpu_dout[7:0];
            r_idx   <= 8'h00;
            r_state <= HALT;
          end
        end
        // a parity-1 HALT lets the first READ land on a parity-0 cycle
        HALT:  r_state <= r_parity ? READ : ALIGN;
        ALIGN: r_state <= READ;
        READ: begin
          r_data_q <= mem_din[7:0];
          r_state  <= WRITE;
        end
        WRITE: begin
          r_idx   <= r_idx + 8'h01;
          r_state <= (r_idx == 8'hFF) ? IDLE : READ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = cpu_addr;
    mem_dout = cpu_dout;
    mem_wen  = cpu_wen;
    unique case (r_state)
      IDLE: ;
      HALT, ALIGN: begin
        mem_addr = ADDR_W'({r_page, 8'h00});
        mem_dout = '0;
        mem_wen  = 1'b0;
      end
      READ: begin
        mem_addr = ADDR_W'({r_page, r_idx});
        mem_dout = '0;
        mem_wen  = 1'b0;
      end
      WRITE: begin
        mem_addr = OAM_DATA_ADDR;
        mem_dout = DATA_W'(r_data_q);
        mem_wen  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter.
// Memory model plus OAM-write and DMA-read logs.
module tb_oam_dma_arbiter;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wen;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_wen;
  logic [7:0]  mem_din;
  logic        dma_busy;

  logic [7:0]  mem [0:65535];
  logic [7:0]  oam_q [$];
  logic [15:0] rd_q [$];
  int          bad_fwd;
  int          cyc;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_wen  (cpu_wen),
    .cpu_din  (cpu_din),
    .cpu_rdy  (cpu_rdy),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_wen  (mem_wen),
    .mem_din  (mem_din),
    .dma_busy (dma_busy)
  );

  assign mem_din = mem[mem_addr];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wen && mem_addr == 16'h2004) oam_q.push_back(mem_dout);
      else if (mem_wen && !dma_busy) mem[mem_addr] = mem_dout;
      if (mem_wen && dma_busy && mem_addr == 16'h4014) bad_fwd++;
      if (dma_busy && !mem_wen) rd_q.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] pg,
                                     input logic [7:0] i);
    case (pg)
      8'h02:   pat = i ^ 8'h5A;
      8'h07:   pat = i ^ 8'hC3;
      default: pat = i + 8'h11;
    endcase
  endfunction

  task automatic trigger(input logic [7:0] pg, input bit halt_par);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (cyc[0] == !halt_par) break;
    end
    cpu_addr = 16'h4014;
    cpu_dout = pg;
    cpu_wen  = 1'b1;
    @(negedge clk);
    chk("trig_fwd_wen", 32'(mem_wen), 32'd1);
    chk("trig_fwd_addr", 32'(mem_addr), 32'h4014);
    @(posedge clk); #1;
    cpu_wen  = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  // counts stalled cycles; optionally pokes the trigger once or holds it
  task automatic wait_idle(input int inj, input bit hold,
                           input logic [7:0] hpg, output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (cpu_rdy) return;
      n++;
      if (n == inj || (hold && n == 1)) begin
        cpu_addr = 16'h4014;
        cpu_dout = hold ? hpg : 8'h55;
        cpu_wen  = 1'b1;
      end else if (!hold && n == inj + 1) begin
        cpu_wen  = 1'b0;
        cpu_addr = 16'h0000;
      end
    end
    chk("stall_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_copy(input string tag, input logic [7:0] pg,
                            input int lead);
    int bad;
    bad = 0;
    chk({tag, "_oam_cnt"}, 32'(oam_q.size()), 32'd256);
    chk({tag, "_rd_cnt"}, 32'(rd_q.size()), 32'(256 + lead));
    if (oam_q.size() == 256)
      for (int i = 0; i < 256; i++)
        if (oam_q[i] !== pat(pg, 8'(i))) bad++;
    chk({tag, "_oam_data"}, 32'(bad), 32'd0);
    bad = 0;
    if (rd_q.size() == 256 + lead) begin
      for (int i = 0; i < lead; i++)
        if (rd_q[i] !== {pg, 8'h00}) bad++;
      for (int i = 0; i < 256; i++)
        if (rd_q[lead + i] !== {pg, 8'(i)}) bad++;
    end
    chk({tag, "_rd_addr"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    int exp_stall;
    checks   = 0;
    errors   = 0;
    bad_fwd  = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = pat(8'h02, 8'(i));
      mem[16'h0700 + i] = pat(8'h07, 8'(i));
      mem[16'h0300 + i] = pat(8'h03, 8'(i));
    end
    rst_n    = 1'b0;
    cpu_addr = 16'h1234;
    cpu_dout = 8'h77;
    cpu_wen  = 1'b1;
    #12;
    chk("rst_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'h1234);
    cpu_wen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // idle passthrough write then read
    @(posedge clk); #1;
    cpu_addr = 16'h0300;
    cpu_dout = 8'hA5;
    cpu_wen  = 1'b1;
    @(negedge clk);
    chk("pt_addr", 32'(mem_addr), 32'h0300);
    chk("pt_dout", 32'(mem_dout), 32'hA5);
    chk("pt_wen", 32'(mem_wen), 32'd1);
    chk("pt_rdy_w", 32'(cpu_rdy), 32'd1);
    @(posedge clk); #1;
    cpu_wen = 1'b0;
    @(negedge clk);
    chk("pt_din", 32'(cpu_din), 32'hA5);
    chk("pt_rdy_r", 32'(cpu_rdy), 32'd1);
    mem[16'h0300] = pat(8'h03, 8'h00);

    // page 02, parity 1 in HALT
    oam_q.delete(); rd_q.delete();
    trigger(8'h02, 1'b1);
    wait_idle(-5, 1'b0, 8'h00, n);
    chk("p1_stall", 32'(n), 32'(STALL_MIN));
    check_copy("p1", 8'h02, 1);

    // page 02, parity 0 in HALT: one ALIGN cycle
    oam_q.delete(); rd_q.delete();
    trigger(8'h02, 1'b0);
    wait_idle(-5, 1'b0, 8'h00, n);
    chk("p0_stall", 32'(n), 32'(STALL_MAX));
    check_copy("p0", 8'h02, 2);

    // retrigger during READ at idx 10 (cycle 22 after trigger)
    oam_q.delete(); rd_q.delete();
    bad_fwd = 0;
    trigger(8'h02, 1'b1);
    wait_idle(21, 1'b0, 8'h00, n);
    chk("rt_stall", 32'(n), 32'(STALL_MIN));
    chk("rt_no_fwd", 32'(bad_fwd), 32'd0);
    check_copy("rt", 8'h02, 1);

    // reset at READ idx 100 (cycle 202 after trigger)
    trigger(8'h02, 1'b1);
    for (int k = 0; k < 202; k++) @(negedge clk);
    chk("mid_busy_pre", 32'(dma_busy), 32'd1);
    #1 rst_n = 1'b0;
    cpu_addr = 16'h0123;
    #1;
    chk("mid_rdy", 32'(cpu_rdy), 32'd1);
    chk("mid_busy", 32'(dma_busy), 32'd0);
    chk("mid_pt_addr", 32'(mem_addr), 32'h0123);
    @(negedge clk);
    rst_n = 1'b1;
    oam_q.delete(); rd_q.delete();

    // page 07 after reset, holding a page-03 trigger for back-to-back
    trigger(8'h07, 1'b1);
    wait_idle(-5, 1'b1, 8'h03, n);
    chk("p7_stall", 32'(n), 32'(STALL_MIN));
    check_copy("p7", 8'h07, 1);
    chk("b2b_fwd_wen", 32'(mem_wen), 32'd1);
    chk("b2b_fwd_addr", 32'(mem_addr), 32'h4014);
    exp_stall = cyc[0] ? STALL_MAX : STALL_MIN;
    oam_q.delete(); rd_q.delete();
    @(posedge clk); #1;
    cpu_wen  = 1'b0;
    cpu_addr = 16'h0000;
    @(negedge clk);
    chk("b2b_busy", 32'(dma_busy), 32'd1);
    wait_idle(-5, 1'b0, 8'h00, n);
    chk("b2b_stall", 32'(n + 1), 32'(exp_stall));
    check_copy("b2b", 8'h03, exp_stall - STALL_MIN + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
